// File: rtl/sd_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : sd_spi_master
// Purpose  : Byte-level SPI master (mode 0, MSB first, single data lane) for
//            SD cards in SPI mode. Drives the SD/quad-SPI bridge and samples
//            MISO from spi_dq_i[1], which arrives through the bridge's 2-flop
//            synchronizer.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            div                 - SCK half-period select, H = max(div,2)+1
//            cs_req              - request card selected
//            tx_valid/tx_ready   - TX byte handshake, tx_data = byte to send
//            rx_valid/rx_data    - one-cycle pulse with the received byte
//            busy                - transfer or init sequence in progress
//            spi_sck, spi_dq_o   - SPI clock, {3'b000, mosi}
//            spi_dq_i            - bridge returns, MISO = bit 1
//            spi_cs              - active-low chip select
//            init_start/init_done (only with SD_SPI_INIT_CLK_EN)
// Options  : `define SD_SPI_INIT_CLK_EN adds the card power-up clock sequence
//            (INIT_CLKS SCK periods with CS and MOSI high).
// Revision : 1.0 - initial release
// ============================================================================
module sd_spi_master #(
    parameter int DIV_W     = 8,
    parameter int INIT_CLKS = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             cs_req,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [7:0]       tx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_data,
    output logic             busy,
    output logic             spi_sck,
    output logic [3:0]       spi_dq_o,
    input  logic [3:0]       spi_dq_i,
    output logic             spi_cs
`ifdef SD_SPI_INIT_CLK_EN
    ,
    input  logic             init_start,
    output logic             init_done
`endif
);

`ifdef SD_SPI_INIT_CLK_EN
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LEAD     = 3'd1,
        S_LOW      = 3'd2,
        S_HIGH     = 3'd3,
        S_DONE     = 3'd4,
        S_INIT     = 3'd5,
        S_INIT_END = 3'd6
    } state_t;

    localparam int c_ICNT_W = $clog2(INIT_CLKS + 1);
    localparam logic [c_ICNT_W-1:0] c_ICNT_LAST = c_ICNT_W'(INIT_CLKS - 1);

    logic                r_init_hi;   // current SCK level during init
    logic [c_ICNT_W-1:0] r_init_cnt;  // completed init SCK periods
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_LOW  = 3'd2,
        S_HIGH = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int c_unused_init_clks = INIT_CLKS;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [DIV_W-1:0] r_cnt;       // cycles spent in current phase
    logic [DIV_W-1:0] r_hm1;       // latched H-1
    logic [DIV_W-1:0] w_hm1;
    logic [2:0]       r_bit;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic             r_cs_active;
    logic             w_phase_end;
    logic             w_mosi;
    logic             w_unused_dq;

    // div < 2 is clamped so that H >= 3 always covers the 2-cycle MISO path.
    assign w_hm1       = (div < DIV_W'(2)) ? DIV_W'(2) : div;
    assign w_phase_end = (r_cnt == r_hm1);
    assign w_unused_dq = ^{spi_dq_i[3:2], spi_dq_i[0]};

    assign spi_dq_o = {3'b000, w_mosi};
    assign spi_cs   = ~r_cs_active;
    assign rx_data  = r_rx;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        tx_ready = 1'b0;
        busy     = 1'b1;
        spi_sck  = 1'b0;
        w_mosi   = 1'b1;
        rx_valid = 1'b0;
`ifdef SD_SPI_INIT_CLK_EN
        init_done = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                tx_ready = ~reset;
                busy     = 1'b0;
`ifdef SD_SPI_INIT_CLK_EN
                if (init_start) begin
                    w_next = S_INIT;
                end else
`endif
                if (tx_valid) begin
                    // CS setup phase only when the card is newly selected.
                    w_next = (cs_req && !r_cs_active) ? S_LEAD : S_LOW;
                end
            end
            S_LEAD: begin
                if (w_phase_end) w_next = S_LOW;
            end
            S_LOW: begin
                w_mosi = r_tx[7];
                if (w_phase_end) w_next = S_HIGH;
            end
            S_HIGH: begin
                spi_sck = 1'b1;
                w_mosi  = r_tx[7];
                if (w_phase_end) w_next = (r_bit == 3'd7) ? S_DONE : S_LOW;
            end
            S_DONE: begin
                rx_valid = 1'b1;
                w_next   = S_IDLE;
            end
`ifdef SD_SPI_INIT_CLK_EN
            S_INIT: begin
                spi_sck = r_init_hi;
                if (w_phase_end && r_init_hi && (r_init_cnt == c_ICNT_LAST)) begin
                    w_next = S_INIT_END;
                end
            end
            S_INIT_END: begin
                init_done = 1'b1;
                w_next    = S_IDLE;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: divider, bit counter, shift registers, chip select
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_hm1       <= DIV_W'(2);
            r_bit       <= 3'd0;
            r_tx        <= 8'hFF;
            r_rx        <= 8'h00;
            r_cs_active <= 1'b0;
`ifdef SD_SPI_INIT_CLK_EN
            r_init_hi   <= 1'b0;
            r_init_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt       <= '0;
                    r_bit       <= 3'd0;
                    // CS only tracks the request while idle, so it never
                    // moves in the middle of a byte.
                    r_cs_active <= cs_req;
`ifdef SD_SPI_INIT_CLK_EN
                    if (init_start) begin
                        r_hm1       <= w_hm1;
                        r_cs_active <= 1'b0;
                        r_init_hi   <= 1'b0;
                        r_init_cnt  <= '0;
                    end else
`endif
                    if (tx_valid) begin
                        r_tx  <= tx_data;
                        r_hm1 <= w_hm1;
                    end
                end
                S_HIGH: begin
                    r_cnt <= w_phase_end ? '0 : r_cnt + DIV_W'(1);
                    if (w_phase_end) begin
                        r_rx <= {r_rx[6:0], spi_dq_i[1]};
                        r_tx <= {r_tx[6:0], 1'b1};
                        if (r_bit != 3'd7) r_bit <= r_bit + 3'd1;
                    end
                end
`ifdef SD_SPI_INIT_CLK_EN
                S_INIT: begin
                    r_cnt <= w_phase_end ? '0 : r_cnt + DIV_W'(1);
                    if (w_phase_end) begin
                        r_init_hi <= ~r_init_hi;
                        if (r_init_hi) r_init_cnt <= r_init_cnt + c_ICNT_W'(1);
                    end
                end
`endif
                default: begin
                    r_cnt <= w_phase_end ? '0 : r_cnt + DIV_W'(1);
                end
            endcase
        end
    end

endmodule
`default_nettype wire
